// File: rtl/pcie_ss_axis_pkg.sv
// Shared types for the PCIe SS AXI-S path: stored beat layout and packet-buffer state encoding.
package pcie_ss_axis_pkg;

    localparam int TDATA_WIDTH        = 512;
    localparam int TKEEP_WIDTH        = TDATA_WIDTH / 8;
    localparam int TUSER_VENDOR_WIDTH = 10;

    typedef struct packed {
        logic                          tlast;
        logic [TUSER_VENDOR_WIDTH-1:0] tuser_vendor;
        logic [TDATA_WIDTH-1:0]        tdata;
        logic [TKEEP_WIDTH-1:0]        tkeep;
    } t_axis_pcie;

    localparam int T_AXIS_PCIE_WIDTH = $bits(t_axis_pcie);

    typedef enum logic {
        STORE = 1'b0,
        CUT   = 1'b1
    } t_pkt_buf_state;

endpackage

// File: rtl/pcie_ss_axis_if.sv
// AXI-Stream bundle for the PCIe SS path with sink/source views.
interface pcie_ss_axis_if;
    import pcie_ss_axis_pkg::*;

    logic                          tvalid;
    logic                          tready;
    logic [TDATA_WIDTH-1:0]        tdata;
    logic [TKEEP_WIDTH-1:0]        tkeep;
    logic                          tlast;
    logic [TUSER_VENDOR_WIDTH-1:0] tuser_vendor;

    modport sink   (input  tvalid, tdata, tkeep, tlast, tuser_vendor, output tready);
    modport source (output tvalid, tdata, tkeep, tlast, tuser_vendor, input  tready);

endinterface

// File: rtl/pcie_axis_pkt_buf_ram.sv
// Simple dual-port beat store with registered read; a write to the address being read
// in the same cycle is forwarded so the head entry is always current.
module pcie_axis_pkt_buf_ram
    import pcie_ss_axis_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [DEPTH_LOG2-1:0]        wr_addr,
    input  logic [T_AXIS_PCIE_WIDTH-1:0] wr_data,
    input  logic [DEPTH_LOG2-1:0]        rd_addr,
    output logic [T_AXIS_PCIE_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [T_AXIS_PCIE_WIDTH-1:0] mem [DEPTH];
    logic [T_AXIS_PCIE_WIDTH-1:0] rd_word_q;
    logic [T_AXIS_PCIE_WIDTH-1:0] byp_word_q;
    logic                         byp_hit_d;
    logic                         byp_hit_q;

    always_comb begin
        byp_hit_d = wr_en && (wr_addr == rd_addr);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_word_q  <= mem[rd_addr];
        byp_hit_q  <= byp_hit_d;
        byp_word_q <= wr_data;
    end

    assign rd_data = byp_hit_q ? byp_word_q : rd_word_q;

endmodule

// File: rtl/pcie_axis_pkt_buffer.sv
// Store-and-forward TLP buffer ahead of the CDC FIFO, falling back to cut-through for packets
// larger than the buffer. Define PCIE_AXIS_PKT_BUF_STATS_EN to add packet/cut statistics.
module pcie_axis_pkt_buffer
    import pcie_ss_axis_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                clk,
    input  logic                rst,
    pcie_ss_axis_if.sink        snk_if,
    pcie_ss_axis_if.source      src_if,
    output logic [DEPTH_LOG2:0] pkt_count,
    output logic                cut_active
`ifdef PCIE_AXIS_PKT_BUF_STATS_EN
    ,
    output logic [31:0]         stat_pkts,
    output logic [31:0]         stat_cuts
`endif
);

    localparam logic [DEPTH_LOG2:0]   DEPTH_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    logic [DEPTH_LOG2-1:0] wr_ptr_d, wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_d, rd_ptr_q;
    logic [DEPTH_LOG2:0]   used_d, used_q;
    logic [DEPTH_LOG2:0]   pkt_count_d, pkt_count_q;
    t_pkt_buf_state        state_d, state_q;
    logic                  snk_ready_d, snk_ready_q;
    logic                  out_valid_d, out_valid_q;
    t_axis_pcie            out_d, out_q;

    t_axis_pcie                   snk_word;
    t_axis_pcie                   head;
    logic [T_AXIS_PCIE_WIDTH-1:0] ram_rd_data;
    logic [DEPTH_LOG2-1:0]        ram_rd_addr;
    logic                         push;
    logic                         load;
    logic                         release_ok;
    logic                         push_last;
    logic                         pop_last;

    pcie_axis_pkt_buf_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (snk_word),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    always_comb begin
        snk_word.tlast        = snk_if.tlast;
        snk_word.tuser_vendor = snk_if.tuser_vendor;
        snk_word.tdata        = snk_if.tdata;
        snk_word.tkeep        = snk_if.tkeep;
        head                  = t_axis_pcie'(ram_rd_data);

        push       = snk_if.tvalid && snk_ready_q;
        release_ok = (state_q == CUT) || (pkt_count_q != '0);
        load       = (!out_valid_q || src_if.tready) && (used_q != '0) && release_ok;
        push_last  = push && snk_if.tlast;
        pop_last   = load && head.tlast;

        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = load ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        used_d = used_q;
        case ({push, load})
            2'b10:   used_d = used_q + CNT_ONE;
            2'b01:   used_d = used_q - CNT_ONE;
            default: used_d = used_q;
        endcase

        pkt_count_d = pkt_count_q;
        case ({push_last, pop_last})
            2'b10:   pkt_count_d = pkt_count_q + CNT_ONE;
            2'b01:   pkt_count_d = pkt_count_q - CNT_ONE;
            default: pkt_count_d = pkt_count_q;
        endcase

        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_d       = head;
            out_valid_d = 1'b1;
        end else if (src_if.tready) begin
            out_valid_d = 1'b0;
        end

        // A full buffer with no complete packet can only drain by forwarding the partial one.
        state_d = state_q;
        case (state_q)
            STORE:   if (used_q == DEPTH_FULL && pkt_count_q == '0) state_d = CUT;
            CUT:     if (pop_last) state_d = STORE;
            default: state_d = STORE;
        endcase

        // Registered so the sink handshake never depends combinationally on sink inputs.
        snk_ready_d = (used_d != DEPTH_FULL);
        ram_rd_addr = rst ? '0 : rd_ptr_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            used_q      <= '0;
            pkt_count_q <= '0;
            state_q     <= STORE;
            snk_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            used_q      <= used_d;
            pkt_count_q <= pkt_count_d;
            state_q     <= state_d;
            snk_ready_q <= snk_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        out_q <= out_d;
    end

    assign snk_if.tready       = snk_ready_q;
    assign src_if.tvalid       = out_valid_q;
    assign src_if.tdata        = out_q.tdata;
    assign src_if.tkeep        = out_q.tkeep;
    assign src_if.tlast        = out_q.tlast;
    assign src_if.tuser_vendor = out_q.tuser_vendor;
    assign pkt_count           = pkt_count_q;
    assign cut_active          = (state_q == CUT);

`ifdef PCIE_AXIS_PKT_BUF_STATS_EN
    logic [31:0] stat_pkts_d, stat_pkts_q;
    logic [31:0] stat_cuts_d, stat_cuts_q;

    always_comb begin
        stat_pkts_d = stat_pkts_q;
        stat_cuts_d = stat_cuts_q;
        if (pop_last && stat_pkts_q != '1) begin
            stat_pkts_d = stat_pkts_q + 32'd1;
        end
        if (state_q == STORE && state_d == CUT && stat_cuts_q != '1) begin
            stat_cuts_d = stat_cuts_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkts_q <= '0;
            stat_cuts_q <= '0;
        end else begin
            stat_pkts_q <= stat_pkts_d;
            stat_cuts_q <= stat_cuts_d;
        end
    end

    assign stat_pkts = stat_pkts_q;
    assign stat_cuts = stat_cuts_q;
`endif

endmodule

// File: tb/tb_pcie_axis_pkt_buffer.sv
// Directed bench for pcie_axis_pkt_buffer at DEPTH_LOG2=4; stats checks run when
// PCIE_AXIS_PKT_BUF_STATS_EN is defined.
module tb_pcie_axis_pkt_buffer;

    logic       clk;
    logic       rst;
    logic [4:0] pkt_count;
    logic       cut_active;
`ifdef PCIE_AXIS_PKT_BUF_STATS_EN
    logic [31:0] stat_pkts;
    logic [31:0] stat_cuts;
`endif

    pcie_ss_axis_if snk ();
    pcie_ss_axis_if src ();

    pcie_axis_pkt_buffer #(
        .DEPTH_LOG2 (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .snk_if     (snk),
        .src_if     (src),
        .pkt_count  (pkt_count),
        .cut_active (cut_active)
`ifdef PCIE_AXIS_PKT_BUF_STATS_EN
        ,
        .stat_pkts  (stat_pkts),
        .stat_cuts  (stat_cuts)
`endif
    );

    typedef struct {
        logic [15:0] tag;
        logic        last;
        logic        cut;
        logic [9:0]  user;
        int          c;
    } beat_t;

    int    tests_run    = 0;
    int    tests_failed = 0;
    int    cyc          = 0;
    int    sink_acc     = 0;
    int    cut_rise_cyc = -1;
    int    cut_rise_acc = 0;
    bit    prev_cut     = 1'b0;
    beat_t mon_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Observe handshakes mid-cycle, where both sides are stable until the next edge.
    always @(negedge clk) begin
        if (src.tvalid === 1'b1 && src.tready === 1'b1)
            mon_q.push_back('{tag: src.tdata[15:0], last: src.tlast, cut: cut_active,
                              user: src.tuser_vendor, c: cyc});
        if (snk.tvalid === 1'b1 && snk.tready === 1'b1) sink_acc = sink_acc + 1;
        if (cut_active === 1'b1 && !prev_cut) begin
            cut_rise_cyc = cyc;
            cut_rise_acc = sink_acc;
        end
        prev_cut = (cut_active === 1'b1);
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_beat(input logic [15:0] tag, input logic last, output int acc_cyc);
        acc_cyc          = -1;
        snk.tvalid       = 1'b1;
        snk.tdata        = '0;
        snk.tdata[15:0]  = tag;
        snk.tkeep        = '1;
        snk.tlast        = last;
        snk.tuser_vendor = {2'b00, tag[15:8]};
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (snk.tready === 1'b1) begin
                acc_cyc = cyc;
                @(posedge clk);
                #1;
                snk.tvalid = 1'b0;
                snk.tlast  = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL push_timeout: tag %0h not accepted within 200 cycles", tag);
        snk.tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int id, input int nbeats, input int gap, output int last_cyc);
        int a;
        last_cyc = -1;
        for (int b = 0; b < nbeats; b++) begin
            push_beat({8'(id), 8'(b)}, (b == nbeats - 1), a);
            if (b == nbeats - 1) last_cyc = a;
            else idle(gap);
        end
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget; i++) begin
            if (mon_q.size() >= n) break;
            idle(1);
        end
        ok = (mon_q.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (src.tvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tvalid: got %b want 0", src.tvalid); end
        tests_run++;
        if (snk.tready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tready: got %b want 0", snk.tready); end
        tests_run++;
        if (pkt_count !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_pkt_count: got %0d want 0", pkt_count); end
        tests_run++;
        if (cut_active !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_cut_active: got %b want 0", cut_active); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (snk.tready !== 1'b0) begin tests_failed++; $display("[TB] FAIL tready_deassert_cycle: got %b want 0", snk.tready); end
        @(negedge clk);
        tests_run++;
        if (snk.tready !== 1'b1) begin tests_failed++; $display("[TB] FAIL tready_rise: got %b want 1", snk.tready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_pkt();
        int base, a, last_c;
        bit ok;
        src.tready = 1'b1;
        base = mon_q.size();
        for (int b = 0; b < 3; b++) push_beat({8'd1, 8'(b)}, 1'b0, a);
        tests_run++;
        if (src.tvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_early_tvalid: got %b want 0", src.tvalid); end
        tests_run++;
        if (pkt_count !== 5'd0) begin tests_failed++; $display("[TB] FAIL single_count_before: got %0d want 0", pkt_count); end
        push_beat(16'h0103, 1'b1, last_c);
        tests_run++;
        if (pkt_count !== 5'd1) begin tests_failed++; $display("[TB] FAIL single_count_after_last: got %0d want 1", pkt_count); end
        wait_beats(base + 4, 40, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL single_out_timeout: got %0d beats want 4", mon_q.size() - base);
        end else begin
            for (int b = 0; b < 4; b++) begin
                tests_run++;
                if (mon_q[base+b].tag !== {8'd1, 8'(b)} || mon_q[base+b].last !== (b == 3)) begin
                    tests_failed++;
                    $display("[TB] FAIL single_beat%0d: got tag %h last %b", b, mon_q[base+b].tag, mon_q[base+b].last);
                end
                tests_run++;
                if (mon_q[base+b].c !== last_c + 2 + b) begin
                    tests_failed++;
                    $display("[TB] FAIL single_timing%0d: got cycle %0d want %0d", b, mon_q[base+b].c, last_c + 2 + b);
                end
            end
        end
        idle(3);
        tests_run++;
        if (pkt_count !== 5'd0) begin tests_failed++; $display("[TB] FAIL single_count_drained: got %0d want 0", pkt_count); end
    endtask

    task automatic test_gaps();
        int base, last_c;
        bit ok;
        src.tready = 1'b1;
        base = mon_q.size();
        send_pkt(2, 8, 3, last_c);
        wait_beats(base + 8, 40, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL gaps_out_timeout: got %0d beats want 8", mon_q.size() - base);
        end else begin
            for (int b = 0; b < 8; b++) begin
                tests_run++;
                if (mon_q[base+b].tag !== {8'd2, 8'(b)} || mon_q[base+b].c !== last_c + 2 + b) begin
                    tests_failed++;
                    $display("[TB] FAIL gaps_beat%0d: got tag %h cycle %0d want tag %h cycle %0d",
                             b, mon_q[base+b].tag, mon_q[base+b].c, {8'd2, 8'(b)}, last_c + 2 + b);
                end
            end
        end
    endtask

    task automatic test_hold_three();
        int base, l;
        bit ok;
        logic [15:0] exp_tag  [6] = '{16'h0300, 16'h0301, 16'h0400, 16'h0401, 16'h0402, 16'h0500};
        logic        exp_last [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        src.tready = 1'b0;
        base = mon_q.size();
        send_pkt(3, 2, 0, l);
        send_pkt(4, 3, 0, l);
        send_pkt(5, 1, 0, l);
        idle(2);
        tests_run++;
        if (pkt_count !== 5'd3) begin tests_failed++; $display("[TB] FAIL hold_pkt_count: got %0d want 3", pkt_count); end
        tests_run++;
        if (src.tuser_vendor !== 10'd3) begin tests_failed++; $display("[TB] FAIL hold_head_user: got %0d want 3", src.tuser_vendor); end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (src.tvalid !== 1'b1 || src.tdata[15:0] !== 16'h0300) begin
                tests_failed++;
                $display("[TB] FAIL hold_head_stable%0d: got valid %b tag %h want 1 0300", i, src.tvalid, src.tdata[15:0]);
            end
            idle(1);
        end
        src.tready = 1'b1;
        wait_beats(base + 6, 40, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL hold_out_timeout: got %0d beats want 6", mon_q.size() - base);
        end else begin
            for (int i = 0; i < 6; i++) begin
                tests_run++;
                if (mon_q[base+i].tag !== exp_tag[i] || mon_q[base+i].last !== exp_last[i]) begin
                    tests_failed++;
                    $display("[TB] FAIL hold_order%0d: got tag %h last %b want %h %b",
                             i, mon_q[base+i].tag, mon_q[base+i].last, exp_tag[i], exp_last[i]);
                end
            end
        end
        idle(2);
        tests_run++;
        if (pkt_count !== 5'd0) begin tests_failed++; $display("[TB] FAIL hold_count_drained: got %0d want 0", pkt_count); end
    endtask

    task automatic test_cut_through();
        int base, acc0, start_c, l;
        bit ok;
        src.tready = 1'b1;
        base    = mon_q.size();
        acc0    = sink_acc;
        start_c = cyc;
        send_pkt(6, 40, 0, l);
        wait_beats(base + 40, 200, ok);
        tests_run++;
        if (cut_rise_cyc < start_c || cut_rise_acc - acc0 !== 16) begin
            tests_failed++;
            $display("[TB] FAIL cut_entry: rise cycle %0d after %0d beats want 16", cut_rise_cyc, cut_rise_acc - acc0);
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL cut_out_timeout: got %0d beats want 40", mon_q.size() - base);
        end else begin
            tests_run++;
            if (mon_q[base].c !== cut_rise_cyc + 1) begin
                tests_failed++;
                $display("[TB] FAIL cut_first_out: got cycle %0d want %0d", mon_q[base].c, cut_rise_cyc + 1);
            end
            for (int b = 0; b < 40; b++) begin
                tests_run++;
                if (mon_q[base+b].tag !== {8'd6, 8'(b)} || mon_q[base+b].last !== (b == 39)) begin
                    tests_failed++;
                    $display("[TB] FAIL cut_beat%0d: got tag %h last %b", b, mon_q[base+b].tag, mon_q[base+b].last);
                end
            end
            tests_run++;
            if (mon_q[base+38].cut !== 1'b1 || mon_q[base+39].cut !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL cut_exit: cut_active at beats 38/39 got %b/%b want 1/0",
                         mon_q[base+38].cut, mon_q[base+39].cut);
            end
        end
        idle(2);
        tests_run++;
        if (cut_active !== 1'b0 || pkt_count !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL cut_idle: got cut %b count %0d want 0 0", cut_active, pkt_count);
        end
        base = mon_q.size();
        push_beat(16'h0700, 1'b0, l);
        tests_run++;
        if (src.tvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL store_resume_early: got tvalid %b want 0", src.tvalid); end
        push_beat(16'h0701, 1'b1, l);
        wait_beats(base + 2, 20, ok);
        tests_run++;
        if (!ok || mon_q[base].c !== l + 2 || mon_q[base+1].tag !== 16'h0701 || mon_q[base+1].last !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL store_resume: got %0d beats, want first at cycle %0d", mon_q.size() - base, l + 2);
        end
    endtask

    task automatic test_reset_mid_packet();
        int base, a, l;
        bit ok;
        src.tready = 1'b1;
        for (int b = 0; b < 5; b++) push_beat({8'd8, 8'(b)}, 1'b0, a);
        idle(1);
        tests_run++;
        if (src.tvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_held: got tvalid %b want 0", src.tvalid); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests_run++;
        if (src.tvalid !== 1'b0 || pkt_count !== 5'd0 || dut.used_q !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_clear: got tvalid %b count %0d used %0d want 0 0 0", src.tvalid, pkt_count, dut.used_q);
        end
        tests_run++;
        if (snk.tready !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_tready: got %b want 0", snk.tready); end
        idle(1);
        tests_run++;
        if (snk.tready !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrst_tready_rise: got %b want 1", snk.tready); end
        base = mon_q.size();
        send_pkt(9, 3, 0, l);
        wait_beats(base + 3, 20, ok);
        idle(4);
        tests_run++;
        if (!ok || mon_q.size() !== base + 3) begin
            tests_failed++;
            $display("[TB] FAIL midrst_beats: got %0d beats want 3", mon_q.size() - base);
        end else begin
            for (int b = 0; b < 3; b++) begin
                tests_run++;
                if (mon_q[base+b].tag !== {8'd9, 8'(b)}) begin
                    tests_failed++;
                    $display("[TB] FAIL midrst_beat%0d: got tag %h want %h", b, mon_q[base+b].tag, {8'd9, 8'(b)});
                end
            end
        end
    endtask

`ifdef PCIE_AXIS_PKT_BUF_STATS_EN
    task automatic test_stats();
        int base, l;
        bit ok;
        src.tready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        base = mon_q.size();
        for (int p = 0; p < 4; p++) send_pkt(10 + p, 2, 0, l);
        send_pkt(14, 20, 0, l);
        for (int p = 0; p < 5; p++) send_pkt(15 + p, 2, 0, l);
        wait_beats(base + 38, 300, ok);
        idle(3);
        tests_run++;
        if (!ok) begin tests_failed++; $display("[TB] FAIL stats_out_timeout: got %0d beats want 38", mon_q.size() - base); end
        tests_run++;
        if (stat_pkts !== 32'd10) begin tests_failed++; $display("[TB] FAIL stat_pkts: got %0d want 10", stat_pkts); end
        tests_run++;
        if (stat_cuts !== 32'd1) begin tests_failed++; $display("[TB] FAIL stat_cuts: got %0d want 1", stat_cuts); end
    endtask
`endif

    initial begin
        rst              = 1'b1;
        snk.tvalid       = 1'b0;
        snk.tdata        = '0;
        snk.tkeep        = '0;
        snk.tlast        = 1'b0;
        snk.tuser_vendor = '0;
        src.tready       = 1'b1;

        test_reset();
        test_single_pkt();
        test_gaps();
        test_hold_three();
        test_cut_through();
        test_reset_mid_packet();
`ifdef PCIE_AXIS_PKT_BUF_STATS_EN
        test_stats();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
